// File: rtl/turbo_rsc_encoder_pkg.sv
// turbo_rsc_encoder_pkg: block sizes, FSM encoding and tail-register layout for the LTE turbo encoder
package turbo_rsc_encoder_pkg;
  localparam int K_SMALL = 1056;
  localparam int K_LARGE = 6144;
  localparam int CNT_W = 13;
  localparam int TAIL_W = 12;
  localparam int X1_B = 0;
  localparam int Z1_B = 3;
  localparam int X2_B = 6;
  localparam int Z2_B = 9;
  typedef enum logic [1:0] {IDLE, DATA, TERM, TAIL} state_e;
  function automatic logic [CNT_W-1:0] k_last(input logic big);
    return big ? CNT_W'(K_LARGE - 1) : CNT_W'(K_SMALL - 1);
  endfunction
endpackage

// File: rtl/turbo_rsc_encoder_rsc_constituent.sv
// rsc_constituent: one 8-state RSC encoder, feedback 1+D^2+D^3, parity 1+D+D^3
module rsc_constituent (
  input  logic clock,
  input  logic reset,
  input  logic u,
  input  logic step,
  input  logic term,
  output logic x,
  output logic z
);
  logic [2:0] s_q, s_d;
  logic u_eff, a;
  // termination feeds back the register so the feedback bit a is forced to 0
  always_comb begin
    u_eff = term ? s_q[1] ^ s_q[0] : u;
    a = u_eff ^ s_q[1] ^ s_q[0];
    x = u_eff;
    z = a ^ s_q[2] ^ s_q[0];
    s_d = step ? {a, s_q[2:1]} : s_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) s_q <= '0;
    else s_q <= s_d;
endmodule

// File: rtl/turbo_rsc_encoder.sv
// turbo_rsc_encoder: LTE PCCC turbo encoder with two RSC constituents and trellis termination;
// emits K+4 registered d0/d1/d2 triples per block, one cycle after each accepted bit.
module turbo_rsc_encoder
  import turbo_rsc_encoder_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic k_size_6144,
  input  logic in_valid,
  input  logic in_i,
  input  logic in_pii,
  output logic out_valid,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic busy,
  output logic block_done,
  output logic overrun
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] tcnt_q, tcnt_d;
  logic [TAIL_W-1:0] tail_q, tail_d;
  logic big_q, big_d;
  logic [2:0] trip_q, trip_d, tail_trip;
  logic valid_q, done_q, ovr_q;
  logic accept, term, x1, z1, x2, z2, last;
  logic [3:0] ti;
  assign accept = in_valid && (state_q == IDLE || state_q == DATA);
  assign term = state_q == TERM;
  assign ti = {2'b00, tcnt_q};
  assign last = cnt_q == k_last(big_q);
  rsc_constituent u_enc1 (
    .clock(clock), .reset(reset), .u(in_i), .step(accept | term), .term(term), .x(x1), .z(z1)
  );
  rsc_constituent u_enc2 (
    .clock(clock), .reset(reset), .u(in_pii), .step(accept | term), .term(term), .x(x2), .z(z2)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tcnt_d = tcnt_q;
    tail_d = tail_q;
    big_d = big_q;
    case (state_q)
      IDLE: if (in_valid) begin
        big_d = k_size_6144;
        cnt_d = CNT_W'(1);
        state_d = DATA;
      end
      DATA: if (in_valid) begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        state_d = last ? TERM : DATA;
      end
      TERM: begin
        tail_d[4'(X1_B) + ti] = x1;
        tail_d[4'(Z1_B) + ti] = z1;
        tail_d[4'(X2_B) + ti] = x2;
        tail_d[4'(Z2_B) + ti] = z2;
        tcnt_d = tcnt_q == 2'd2 ? 2'd0 : tcnt_q + 2'd1;
        state_d = tcnt_q == 2'd2 ? TAIL : TERM;
      end
      TAIL: begin
        tcnt_d = tcnt_q + 2'd1;
        state_d = tcnt_q == 2'd3 ? IDLE : TAIL;
      end
      default: state_d = IDLE;
    endcase
  end
  // tail triples interleave x/z of encoder 1 first, then encoder 2
  always_comb begin
    tail_trip = tcnt_q[1]
      ? (tcnt_q[0] ? {tail_q[Z2_B+1], tail_q[X2_B+2], tail_q[Z2_B+2]}
                   : {tail_q[X2_B], tail_q[Z2_B], tail_q[X2_B+1]})
      : (tcnt_q[0] ? {tail_q[Z1_B+1], tail_q[X1_B+2], tail_q[Z1_B+2]}
                   : {tail_q[X1_B], tail_q[Z1_B], tail_q[X1_B+1]});
    trip_d = accept ? {x1, z1, z2} : state_q == TAIL ? tail_trip : 3'b000;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tcnt_q <= '0;
      tail_q <= '0;
      big_q <= 1'b0;
      trip_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tcnt_q <= tcnt_d;
      tail_q <= tail_d;
      big_q <= big_d;
      trip_q <= trip_d;
      valid_q <= accept || state_q == TAIL;
      done_q <= state_q == TAIL && tcnt_q == 2'd3;
      ovr_q <= in_valid && (state_q == TERM || state_q == TAIL);
    end
  assign {d0, d1, d2} = trip_q;
  assign out_valid = valid_q;
  assign block_done = done_q;
  assign overrun = ovr_q;
  assign busy = state_q != IDLE || done_q;
endmodule

// File: tb/tb_turbo_rsc_encoder.sv
// tb_turbo_rsc_encoder: directed scenarios against hand-derived vectors and a bit-level encoder model
module tb_turbo_rsc_encoder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic k_size_6144 = 1'b0;
  logic in_valid = 1'b0;
  logic in_i = 1'b0;
  logic in_pii = 1'b0;
  logic out_valid, d0, d1, d2, busy, block_done, overrun;
  int vectors = 0;
  int errors = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  int idle_nz = 0;
  int busy_gap = 0;
  logic ua [6144];
  logic ub [6144];
  logic [2:0] cap [$];
  logic [2:0] exp_q [$];
  always #5 clock = ~clock;
  turbo_rsc_encoder dut (
    .clock(clock), .reset(reset), .k_size_6144(k_size_6144), .in_valid(in_valid),
    .in_i(in_i), .in_pii(in_pii), .out_valid(out_valid), .d0(d0), .d1(d1), .d2(d2),
    .busy(busy), .block_done(block_done), .overrun(overrun)
  );
  always @(negedge clock) begin
    if (out_valid) cap.push_back({d0, d1, d2});
    else if ({d0, d1, d2} != 3'b000) idle_nz++;
    if (out_valid && !busy) busy_gap++;
    if (block_done) done_cnt++;
    if (overrun) ovr_cnt++;
  end
  function automatic logic [4:0] rsc(input logic [2:0] s, input logic u);
    logic a;
    a = u ^ s[1] ^ s[0];
    return {u, a ^ s[2] ^ s[0], a, s[2], s[1]};
  endfunction
  function automatic void build_ref(input int k);
    logic [2:0] e1, e2;
    logic [4:0] r1, r2;
    logic [2:0] xa, za, xb, zb;
    e1 = '0;
    e2 = '0;
    for (int i = 0; i < k; i++) begin
      r1 = rsc(e1, ua[i]);
      r2 = rsc(e2, ub[i]);
      exp_q.push_back({r1[4], r1[3], r2[3]});
      e1 = r1[2:0];
      e2 = r2[2:0];
    end
    for (int t = 0; t < 3; t++) begin
      r1 = rsc(e1, e1[1] ^ e1[0]);
      r2 = rsc(e2, e2[1] ^ e2[0]);
      xa[t] = r1[4]; za[t] = r1[3]; xb[t] = r2[4]; zb[t] = r2[3];
      e1 = r1[2:0];
      e2 = r2[2:0];
    end
    exp_q.push_back({xa[0], za[0], xa[1]});
    exp_q.push_back({za[1], xa[2], za[2]});
    exp_q.push_back({xb[0], zb[0], xb[1]});
    exp_q.push_back({zb[1], xb[2], zb[2]});
  endfunction
  function automatic int stream_errs();
    int e = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= cap.size() || cap[i] !== exp_q[i]) e++;
    return e;
  endfunction
  function automatic void fill_random();
    for (int i = 0; i < 6144; i++) begin
      ua[i] = 1'($urandom);
      ub[i] = 1'($urandom);
    end
  endfunction
  task automatic drive_bits(input int k, input bit big, input bit gaps, input int hold);
    int n = 0;
    bit ph = 1'b1;
    while (n < k) begin
      @(posedge clock); #1;
      k_size_6144 = (n == 0) ? big : !big;
      in_valid = !gaps || ph;
      in_i = in_valid ? ua[n] : 1'($urandom);
      in_pii = in_valid ? ub[n] : 1'($urandom);
      if (in_valid) n++;
      ph = !ph;
    end
    repeat (hold) begin
      @(posedge clock); #1;
      in_valid = 1'b1;
      in_i = 1'($urandom);
      in_pii = 1'($urandom);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_i = 1'b0;
    in_pii = 1'b0;
  endtask
  task automatic wait_done(input int target);
    int c = 0;
    while (done_cnt < target && c < 20000) begin
      @(posedge clock);
      c++;
    end
    repeat (3) @(negedge clock);
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({out_valid, d0, d1, d2, busy, block_done, overrun} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0000000", {out_valid, d0, d1, d2, busy, block_done, overrun});
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask
  task automatic test_all_zero();
    int d_start = done_cnt;
    int ones = 0;
    for (int i = 0; i < 6144; i++) begin ua[i] = 1'b0; ub[i] = 1'b0; end
    cap.delete();
    drive_bits(1056, 1'b0, 1'b0, 0);
    wait_done(d_start + 1);
    foreach (cap[i]) if (cap[i] != 3'b000) ones++;
    vectors++;
    if (cap.size() != 1060) begin errors++; $display("FAIL zero_count got=%0d want=1060", cap.size()); end
    vectors++;
    if (ones != 0) begin errors++; $display("FAIL zero_data nonzero_triples=%0d want=0", ones); end
    vectors++;
    if (done_cnt - d_start != 1) begin errors++; $display("FAIL zero_done got=%0d want=1", done_cnt - d_start); end
  endtask
  task automatic test_impulse();
    int d_start = done_cnt;
    for (int i = 0; i < 6144; i++) begin ua[i] = 1'b0; ub[i] = 1'b0; end
    ua[0] = 1'b1;
    cap.delete();
    drive_bits(1056, 1'b0, 1'b0, 0);
    wait_done(d_start + 1);
    vectors++;
    if (cap.size() != 1060) begin errors++; $display("FAIL imp_count got=%0d want=1060", cap.size()); end
    vectors++;
    if ({cap[0], cap[1], cap[2]} !== {3'b110, 3'b010, 3'b010})
      begin errors++; $display("FAIL imp_head got=%b %b %b want=110 010 010", cap[0], cap[1], cap[2]); end
    vectors++;
    if (cap[1055] !== 3'b000) begin errors++; $display("FAIL imp_last got=%b want=000", cap[1055]); end
    vectors++;
    if ({cap[1056], cap[1057], cap[1058], cap[1059]} !== {3'b011, 3'b100, 3'b000, 3'b000})
      begin errors++; $display("FAIL imp_tail got=%b %b %b %b want=011 100 000 000", cap[1056], cap[1057], cap[1058], cap[1059]); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL imp_busy_after got=%b want=0", busy); end
  endtask
  task automatic test_random_6144();
    int d_start = done_cnt;
    int e;
    fill_random();
    exp_q.delete();
    build_ref(6144);
    cap.delete();
    drive_bits(6144, 1'b1, 1'b0, 0);
    wait_done(d_start + 1);
    e = stream_errs();
    vectors++;
    if (cap.size() != 6148) begin errors++; $display("FAIL big_count got=%0d want=6148", cap.size()); end
    vectors++;
    if (e != 0) begin errors++; $display("FAIL big_data bad_triples=%0d want=0", e); end
  endtask
  task automatic test_gaps();
    int d_start = done_cnt;
    int e;
    fill_random();
    exp_q.delete();
    build_ref(1056);
    cap.delete();
    drive_bits(1056, 1'b0, 1'b1, 0);
    wait_done(d_start + 1);
    e = stream_errs();
    vectors++;
    if (cap.size() != 1060) begin errors++; $display("FAIL gap_count got=%0d want=1060", cap.size()); end
    vectors++;
    if (e != 0) begin errors++; $display("FAIL gap_data bad_triples=%0d want=0", e); end
  endtask
  task automatic test_overrun();
    int d_start = done_cnt;
    int o_start = ovr_cnt;
    int e;
    fill_random();
    exp_q.delete();
    build_ref(1056);
    cap.delete();
    drive_bits(1056, 1'b0, 1'b0, 7);
    wait_done(d_start + 1);
    e = stream_errs();
    vectors++;
    if (ovr_cnt - o_start != 7) begin errors++; $display("FAIL ovr_pulses got=%0d want=7", ovr_cnt - o_start); end
    vectors++;
    if (cap.size() != 1060 || e != 0)
      begin errors++; $display("FAIL ovr_data count=%0d bad_triples=%0d want=1060/0", cap.size(), e); end
  endtask
  task automatic test_back_to_back();
    int d_start = done_cnt;
    int o_start = ovr_cnt;
    int e;
    fill_random();
    exp_q.delete();
    build_ref(1056);
    build_ref(1056);
    cap.delete();
    drive_bits(1056, 1'b0, 1'b0, 0);
    repeat (6) begin @(posedge clock); #1; in_valid = 1'b0; end
    drive_bits(1056, 1'b0, 1'b0, 0);
    wait_done(d_start + 2);
    e = stream_errs();
    vectors++;
    if (cap.size() != 2120 || e != 0)
      begin errors++; $display("FAIL b2b_data count=%0d bad_triples=%0d want=2120/0", cap.size(), e); end
    vectors++;
    if (done_cnt - d_start != 2 || ovr_cnt != o_start)
      begin errors++; $display("FAIL b2b_pulses done=%0d ovr=%0d want=2/0", done_cnt - d_start, ovr_cnt - o_start); end
    vectors++;
    if (idle_nz != 0 || busy_gap != 0)
      begin errors++; $display("FAIL idle_zero nz=%0d busy_gap=%0d want=0/0", idle_nz, busy_gap); end
  endtask
  task automatic test_reset_mid();
    int d_start = done_cnt;
    int e;
    fill_random();
    for (int n = 0; n < 500; n++) begin
      @(posedge clock); #1;
      k_size_6144 = 1'b1;
      in_valid = 1'b1;
      in_i = ua[n];
      in_pii = ub[n];
    end
    @(posedge clock); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    vectors++;
    if ({out_valid, d0, d1, d2, busy, block_done, overrun} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%b want=0000000", {out_valid, d0, d1, d2, busy, block_done, overrun});
    end
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    vectors++;
    if (done_cnt != d_start) begin errors++; $display("FAIL mid_reset_done got=%0d want=0", done_cnt - d_start); end
    fill_random();
    exp_q.delete();
    build_ref(1056);
    cap.delete();
    drive_bits(1056, 1'b0, 1'b0, 0);
    wait_done(d_start + 1);
    e = stream_errs();
    vectors++;
    if (cap.size() != 1060 || e != 0)
      begin errors++; $display("FAIL mid_reset_block count=%0d bad_triples=%0d want=1060/0", cap.size(), e); end
  endtask
  initial begin
    test_reset();
    test_all_zero();
    test_impulse();
    test_random_6144();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
